// File: rtl/cond_logic.sv
// Condition-logic stage: holds the NZCV flags register, evaluates the ARM
// condition field against it and gates the decoder's commit strobes.
module cond_logic #(
  parameter bit         NV_EXECUTES = 1'b0,
  parameter logic [3:0] FLAGS_RST   = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stall,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = Flags;

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      4'b1110: CondEx = 1'b1;
      4'b1111: CondEx = NV_EXECUTES;
      default: CondEx = 1'b0;
    endcase
  end

  // Flags only change for condition-passing, non-stalled instructions;
  // the N,Z and C,V halves are written independently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Flags <= FLAGS_RST;
    end else if (!stall && CondEx) begin
      if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // reset_n gates the strobes combinationally so a mid-cycle reset commits nothing.
  assign PCSrc    = PCS  & CondEx & reset_n;
  assign RegWrite = RegW & CondEx & reset_n;
  assign MemWrite = MemW & CondEx & reset_n;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed vector table, multi-cycle
// reset corner cases, exhaustive condition sweep and randomized model run.
module tb_cond_logic;

  logic       clk;
  logic       reset_n;
  logic       stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;

  logic       pc_src    [2];
  logic       reg_write [2];
  logic       mem_write [2];
  logic       cond_ex   [2];
  logic [3:0] flags     [2];

  localparam logic [3:0] RST0 = 4'b0000;
  localparam logic [3:0] RST1 = 4'b1010;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] mflags [2];

  // Instance 0: NV never executes, default reset value.
  cond_logic #(.NV_EXECUTES(1'b0), .FLAGS_RST(RST0)) dut0 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(pc_src[0]), .RegWrite(reg_write[0]), .MemWrite(mem_write[0]),
    .CondEx(cond_ex[0]), .Flags(flags[0])
  );

  // Instance 1: NV executes, non-zero reset value.
  cond_logic #(.NV_EXECUTES(1'b1), .FLAGS_RST(RST1)) dut1 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(pc_src[1]), .RegWrite(reg_write[1]), .MemWrite(mem_write[1]),
    .CondEx(cond_ex[1]), .Flags(flags[1])
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: even codes test a predicate, the following odd code is its inverse.
  function automatic bit cond_ref(input logic [3:0] c, input logic [3:0] f, input bit nv);
    bit fn, fz, fc, fv, base;
    fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return nv;
    case (c >> 1)
      3'd0:    base = fz;
      3'd1:    base = fc;
      3'd2:    base = fn;
      3'd3:    base = fv;
      3'd4:    base = fc && !fz;
      3'd5:    base = (fn == fv);
      default: base = !fz && (fn == fv);
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rn, input logic st, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fw, input logic [2:0] strb);
    reset_n = rn; stall = st; Cond = c; ALUFlags = alu; FlagW = fw;
    {PCS, RegW, MemW} = strb;
  endtask

  function automatic logic [2:0] strobes(input int k);
    return {pc_src[k], reg_write[k], mem_write[k]};
  endfunction

  typedef struct {
    logic       stall;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic [2:0] strb;
    logic [2:0] exp_strb;
    logic       exp_ex;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 4'b1110, 4'b0100, 2'b11, 3'b111, 3'b111, 1'b1, 4'b0100};
    vecs[1]  = '{1'b0, 4'b0000, 4'b0000, 2'b00, 3'b101, 3'b101, 1'b1, 4'b0100};
    vecs[2]  = '{1'b0, 4'b0001, 4'b0000, 2'b00, 3'b111, 3'b000, 1'b0, 4'b0100};
    vecs[3]  = '{1'b0, 4'b1110, 4'b1011, 2'b01, 3'b010, 3'b010, 1'b1, 4'b0111};
    vecs[4]  = '{1'b0, 4'b1000, 4'b0000, 2'b00, 3'b111, 3'b000, 1'b0, 4'b0111};
    vecs[5]  = '{1'b0, 4'b1001, 4'b0000, 2'b00, 3'b100, 3'b100, 1'b1, 4'b0111};
    vecs[6]  = '{1'b0, 4'b1110, 4'b0000, 2'b11, 3'b000, 3'b000, 1'b1, 4'b0000};
    vecs[7]  = '{1'b0, 4'b0000, 4'b1111, 2'b11, 3'b111, 3'b000, 1'b0, 4'b0000};
    vecs[8]  = '{1'b1, 4'b1110, 4'b1001, 2'b11, 3'b011, 3'b011, 1'b1, 4'b0000};
    vecs[9]  = '{1'b0, 4'b1110, 4'b1001, 2'b11, 3'b000, 3'b000, 1'b1, 4'b1001};
    vecs[10] = '{1'b0, 4'b1010, 4'b0000, 2'b00, 3'b001, 3'b001, 1'b1, 4'b1001};
    vecs[11] = '{1'b0, 4'b1011, 4'b0000, 2'b00, 3'b111, 3'b000, 1'b0, 4'b1001};

    // Reset held for two edges with every write request active.
    drive(1'b0, 1'b0, 4'b1110, 4'b1111, 2'b11, 3'b111);
    #1;
    check("rst_strobes_pre_edge", {1'b0, strobes(0)}, 4'b0000);
    for (int e = 0; e < 2; e++) begin
      tick();
      check("rst_flags0", flags[0], RST0);
      check("rst_flags1", flags[1], RST1);
      check("rst_strobes0", {1'b0, strobes(0)}, 4'b0000);
      check("rst_strobes1", {1'b0, strobes(1)}, 4'b0000);
      check("rst_condex_al", {3'b000, cond_ex[0]}, 4'b0001);
    end

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].stall, vecs[i].cond, vecs[i].alu, vecs[i].flagw, vecs[i].strb);
      #1;
      check($sformatf("vec%0d_condex", i), {3'b000, cond_ex[0]}, {3'b000, vecs[i].exp_ex});
      check($sformatf("vec%0d_strobes", i), {1'b0, strobes(0)}, {1'b0, vecs[i].exp_strb});
      tick();
      check($sformatf("vec%0d_flags", i), flags[0], vecs[i].exp_flags);
    end

    // Reset arriving mid-cycle kills the strobes immediately.
    drive(1'b1, 1'b0, 4'b1110, 4'b0000, 2'b00, 3'b111);
    #1;
    check("mid_pre_strobes", {1'b0, strobes(0)}, 4'b0111);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobes0", {1'b0, strobes(0)}, 4'b0000);
    check("mid_rst_strobes1", {1'b0, strobes(1)}, 4'b0000);
    check("mid_rst_condex", {3'b000, cond_ex[0]}, 4'b0001);
    tick();
    check("mid_rst_flags0", flags[0], RST0);
    check("mid_rst_flags1", flags[1], RST1);

    // Exhaustive sweep: load each flag value via AL, then try every condition.
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 1'b0, 4'b1110, 4'(f), 2'b11, 3'b000);
      tick();
      check("sweep_load0", flags[0], 4'(f));
      check("sweep_load1", flags[1], 4'(f));
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        FlagW = 2'b00;
        #1;
        for (int k = 0; k < 2; k++)
          check($sformatf("sweep_nv%0d_f%0h_c%0h", k, f, c), {3'b000, cond_ex[k]},
                {3'b000, cond_ref(4'(c), 4'(f), k == 1)});
      end
    end

    // Randomized run against the model, with a scoreboard queue of next-state flags.
    drive(1'b0, 1'b0, 4'b1110, 4'b0000, 2'b00, 3'b000);
    tick();
    mflags[0] = RST0;
    mflags[1] = RST1;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) == 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      #1;
      for (int k = 0; k < 2; k++) begin
        bit ex;
        logic [3:0] nf;
        ex = cond_ref(Cond, mflags[k], k == 1);
        check($sformatf("rnd%0d_condex%0d", i, k), {3'b000, cond_ex[k]}, {3'b000, ex});
        check($sformatf("rnd%0d_strobes%0d", i, k), {1'b0, strobes(k)},
              {1'b0, {PCS, RegW, MemW} & {3{ex && reset_n}}});
        nf = mflags[k];
        if (!reset_n) nf = (k == 0) ? RST0 : RST1;
        else if (!stall && ex) begin
          if (FlagW[1]) nf[3:2] = ALUFlags[3:2];
          if (FlagW[0]) nf[1:0] = ALUFlags[1:0];
        end
        exp_q.push_back(nf);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        mflags[k] = exp_q.pop_front();
        check($sformatf("rnd%0d_flags%0d", i, k), flags[k], mflags[k]);
      end
    end

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
